// File: rtl/proc_ctrl_pkg.sv
// Shared types and field-position helpers for the single-step processor controller.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_MOVE = 2'd1,
    OP_ADD  = 2'd2,
    OP_SUB  = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_DIN  = 2'd1,
    BUS_REG  = 2'd2,
    BUS_G    = 2'd3
  } bus_sel_t;

  localparam int OP_W = 2;

  // Fields pack from the top of the word: op, rx, ry, then unused low bits.
  function automatic int op_lsb(input int data_w);
    return data_w - OP_W;
  endfunction

  function automatic int rx_lsb(input int data_w, input int reg_w);
    return data_w - OP_W - reg_w;
  endfunction

  function automatic int ry_lsb(input int data_w, input int reg_w);
    return data_w - OP_W - 2 * reg_w;
  endfunction

endpackage

// File: rtl/step_edge.sv
// Registers a debounced button level and emits a one-cycle pulse on its rising edge.
module step_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic adv
);

  logic step_d;
  logic step_q;

  always_comb begin
    step_d = step;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset high: a button held through reset must not look like a fresh press.
      step_q <= 1'b1;
    end else begin
      step_q <= step_d;
    end
  end

  assign adv = step & ~step_q;

endmodule

// File: rtl/step_controller.sv
// Single-step control unit: one timestep per button press, decodes ir into bus selects and strobes.
// Build option: define AUTO_RUN_EN to add a `run` input that advances every clock while high.
module step_controller
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int NREG   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step,
`ifdef AUTO_RUN_EN
  input  logic                     run,
`endif
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        ir,
  output logic [1:0]               timestep,
  output logic [1:0]               bus_sel,
  output logic [$clog2(NREG)-1:0]  reg_sel,
  output logic [NREG-1:0]          reg_we,
  output logic                     a_we,
  output logic                     g_we,
  output logic                     alu_sub,
  output logic                     done
);

  localparam int REG_W  = $clog2(NREG);
  localparam int OP_LSB = op_lsb(DATA_W);
  localparam int RX_LSB = rx_lsb(DATA_W, REG_W);
  localparam int RY_LSB = ry_lsb(DATA_W, REG_W);

  logic btn_adv;
  logic adv;

  step_edge u_step_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .adv   (btn_adv)
  );

`ifdef AUTO_RUN_EN
  assign adv = btn_adv | run;
`else
  assign adv = btn_adv;
`endif

  tstep_t            ts_q, ts_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  opcode_t           op;
  logic [REG_W-1:0]  rx;
  logic [REG_W-1:0]  ry;

  assign op = opcode_t'(ir_q[OP_LSB +: OP_W]);
  assign rx = ir_q[RX_LSB +: REG_W];
  assign ry = ir_q[RY_LSB +: REG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= T0;
      ir_q <= '0;
    end else begin
      ts_q <= ts_d;
      ir_q <= ir_d;
    end
  end

  bus_sel_t         bus_d;
  logic [REG_W-1:0] reg_sel_d;
  logic             alu_sub_d;
  logic             wr_rx;
  logic             a_we_d;
  logic             g_we_d;
  logic             done_d;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    ts_d      = ts_q;
    ir_d      = ir_q;
    bus_d     = BUS_NONE;
    reg_sel_d = '0;
    alu_sub_d = 1'b0;
    wr_rx     = 1'b0;
    a_we_d    = 1'b0;
    g_we_d    = 1'b0;
    done_d    = 1'b0;

    case (ts_q)
      T0: begin
        bus_d = BUS_DIN;
        if (adv) begin
          ir_d = din;
          ts_d = T1;
        end
      end

      T1: begin
        case (op)
          OP_LOAD: begin
            bus_d = BUS_DIN;
            if (adv) begin
              wr_rx  = 1'b1;
              done_d = 1'b1;
              ts_d   = T0;
            end
          end
          OP_MOVE: begin
            bus_d     = BUS_REG;
            reg_sel_d = ry;
            if (adv) begin
              wr_rx  = 1'b1;
              done_d = 1'b1;
              ts_d   = T0;
            end
          end
          default: begin
            // ADD/SUB: first operand goes to A.
            bus_d     = BUS_REG;
            reg_sel_d = rx;
            if (adv) begin
              a_we_d = 1'b1;
              ts_d   = T2;
            end
          end
        endcase
      end

      T2: begin
        bus_d     = BUS_REG;
        reg_sel_d = ry;
        alu_sub_d = (op == OP_SUB);
        if (adv) begin
          g_we_d = 1'b1;
          ts_d   = T3;
        end
      end

      T3: begin
        bus_d = BUS_G;
        if (adv) begin
          wr_rx  = 1'b1;
          done_d = 1'b1;
          ts_d   = T0;
        end
      end

      default: begin
        if (adv) begin
          ts_d = T0;
        end
      end
    endcase
  end

  assign ir       = ir_q;
  assign timestep = ts_q;
  assign bus_sel  = bus_d;
  assign reg_sel  = reg_sel_d;
  assign alu_sub  = alu_sub_d;
  assign reg_we   = wr_rx ? (NREG'(1) << rx) : '0;
  assign a_we     = a_we_d;
  assign g_we     = g_we_d;
  assign done     = done_d;

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller: directed scenarios then random instructions vs a behavioural model.
module tb_step_controller;

  localparam int DATA_W = 10;
  localparam int NREG   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              step;
  logic              run;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] ir;
  logic [1:0]        timestep;
  logic [1:0]        bus_sel;
  logic [1:0]        reg_sel;
  logic [NREG-1:0]   reg_we;
  logic              a_we;
  logic              g_we;
  logic              alu_sub;
  logic              done;

  step_controller #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
`ifdef AUTO_RUN_EN
    .run      (run),
`endif
    .din      (din),
    .ir       (ir),
    .timestep (timestep),
    .bus_sel  (bus_sel),
    .reg_sel  (reg_sel),
    .reg_we   (reg_we),
    .a_we     (a_we),
    .g_we     (g_we),
    .alu_sub  (alu_sub),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position within the instruction and the latched word.
  int                m_ts;
  logic [DATA_W-1:0] m_ir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // An instruction is a sequence of micro-steps: fetch, then 1 (LOAD/MOVE) or 3 (ADD/SUB) execute steps.
  function automatic int steps_of(input logic [DATA_W-1:0] w);
    return (w[9:8] < 2) ? 2 : 4;
  endfunction

  task automatic compare_all(input string tag, input bit adv);
    int   op, rx, ry, last;
    int   e_bus, e_rsel, e_asub;
    logic [NREG-1:0] e_rwe;
    bit   e_awe, e_gwe, e_done;
    op = int'(m_ir[9:8]);
    rx = int'(m_ir[7:6]);
    ry = int'(m_ir[5:4]);
    last = steps_of(m_ir) - 1;
    e_rsel = -1;
    e_asub = -1;
    e_rwe = '0;
    e_awe = 0;
    e_gwe = 0;
    e_done = 0;
    if (m_ts == 0) begin
      e_bus = 1;
    end else if (m_ts == last) begin
      // Final step writes rx from wherever the result lives.
      if (op == 0) e_bus = 1;
      else if (op == 1) begin e_bus = 2; e_rsel = ry; end
      else e_bus = 3;
      if (adv) begin e_rwe[rx] = 1'b1; e_done = 1; end
    end else if (m_ts == 1) begin
      e_bus = 2; e_rsel = rx;
      e_awe = adv;
    end else begin
      e_bus = 2; e_rsel = ry; e_asub = op - 2;
      e_gwe = adv;
    end
    check({tag, ".timestep"}, 32'(timestep), 32'(m_ts));
    check({tag, ".ir"},       32'(ir),       32'(m_ir));
    check({tag, ".bus_sel"},  32'(bus_sel),  32'(e_bus));
    if (e_rsel >= 0) check({tag, ".reg_sel"}, 32'(reg_sel), 32'(e_rsel));
    if (e_asub >= 0) check({tag, ".alu_sub"}, 32'(alu_sub), 32'(e_asub));
    check({tag, ".reg_we"},   32'(reg_we),   32'(e_rwe));
    check({tag, ".a_we"},     32'(a_we),     32'(e_awe));
    check({tag, ".g_we"},     32'(g_we),     32'(e_gwe));
    check({tag, ".done"},     32'(done),     32'(e_done));
  endtask

  task automatic model_advance();
    if (m_ts == 0) m_ir = din;
    m_ts = (m_ts + 1) % steps_of(m_ir);
  endtask

  // One button press held for `hold` cycles, checked in the adv cycle and every held cycle after.
  task automatic press(input string tag, input int hold);
    @(posedge clk);
    #1 step = 1'b1;
    #3 compare_all({tag, ".adv"}, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      if (i == 0) model_advance();
      #1 compare_all({tag, ".held"}, 1'b0);
    end
    step = 1'b0;
    @(posedge clk);
    #1 compare_all({tag, ".rel"}, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    step  = 1'b1;
    run   = 1'b0;
    din   = '0;
    m_ts  = 0;
    m_ir  = '0;
    repeat (3) @(posedge clk);
    #1 compare_all("reset", 1'b0);
    check("reset.reg_sel", 32'(reg_sel), 32'd0);
    check("reset.alu_sub", 32'(alu_sub), 32'd0);

    // Release reset with the button still held: no pulse may appear.
    #4 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 compare_all("held_thru_reset", 1'b0);
    end
    step = 1'b0;
    @(posedge clk);

    // LOAD R1, then the immediate 0x05A on the switches.
    din = 10'h040;
    press("load_t0", 1);
    check("load.ir", 32'(ir), 32'h040);
    check("load.ts", 32'(timestep), 32'd1);
    din = 10'h05A;
    press("load_t1", 1);

    // ADD R2,R3 then SUB R0,R0.
    din = 10'h2B0;
    for (int i = 0; i < 4; i++) press("add", 1);
    din = 10'h300;
    for (int i = 0; i < 4; i++) press("sub", 1);

    // Long hold advances exactly one timestep.
    din = 10'h1D0;
    press("long_hold", 500);
    check("long_hold.ts", 32'(timestep), 32'd1);
    press("move_t1", 1);

    // Reset during T2 of an ADD, then a clean new instruction.
    din = 10'h2B0;
    press("abort_t0", 1);
    press("abort_t1", 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    m_ts = 0;
    m_ir = '0;
    #1 compare_all("abort_rst", 1'b0);
    #1 rst_n = 1'b1;
    din = 10'h1D0;
    press("after_abort_t0", 1);
    press("after_abort_t1", 1);

    // Random instructions, random hold lengths, switches changing between presses.
    for (int n = 0; n < 200; n++) begin
      din = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      press("rand", $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1 compare_all("rand_idle", 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
